// File: rtl/sort6_framer_pkg.sv
// Shared types and sizing for the 6-element byte sort framer.
// The FSM states and frame geometry are used by both the top and the sorter.
package sort6_framer_pkg;

   localparam int unsigned FRAME_N = 6;
   localparam int unsigned DATA_W  = 8;

   localparam logic [2:0] LAST_SLOT = 3'(FRAME_N - 1);

   typedef enum logic [1:0] {
      COLLECT,
      SORT,
      EMIT
   } state_t;

   typedef logic [FRAME_N-1:0][DATA_W-1:0] frame_t;

endpackage

// File: rtl/sort6_framer_mmmmmm.sv
// Combinational 6-input unsigned sorter; element 0 of the result is the minimum.
// Odd-even transposition network: FRAME_N stages are sufficient for FRAME_N inputs.
module mmmmmm
   import sort6_framer_pkg::*;
(
   input  frame_t unsorted,
   output frame_t sorted
);

   frame_t            v;
   logic [DATA_W-1:0] t;

   always_comb begin
      v = unsorted;
      t = '0;
      for (int unsigned s = 0; s < FRAME_N; s++) begin
         for (int unsigned i = s % 2; i + 1 < FRAME_N; i += 2) begin
            if (v[i] > v[i+1]) begin
               t      = v[i];
               v[i]   = v[i+1];
               v[i+1] = t;
            end
         end
      end
      sorted = v;
   end

endmodule

// File: rtl/sort6_framer.sv
// Collects six bytes, sorts them in one cycle, then streams them out smallest first.
// Input and output handshakes are mutually exclusive: a frame is fully drained before the next is accepted.
module sort6_framer
   import sort6_framer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   state_t     state;
   logic [2:0] cnt;
   logic [2:0] idx;
   logic [2:0] idx_nxt;
   frame_t     in_buf;
   frame_t     out_buf;
   frame_t     sorted;
   logic       in_fire;
   logic       out_fire;

   assign in_ready = (state == COLLECT);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign idx_nxt  = idx + 3'd1;
   assign busy     = (state != COLLECT) || (cnt != '0);

   mmmmmm u_mmmmmm (
      .unsorted (in_buf),
      .sorted   (sorted)
   );

   // Data buffers carry no reset; only the control path decides what is emitted.
   always_ff @(posedge clk) begin
      if (in_fire)
         in_buf[cnt] <= in_data;
      if (state == SORT)
         out_buf <= sorted;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         cnt       <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (in_fire) begin
                  if (cnt == LAST_SLOT) begin
                     cnt   <= '0;
                     state <= SORT;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            SORT: begin
               idx   <= '0;
               state <= EMIT;
            end
            EMIT: begin
               // First EMIT cycle loads the output register from the freshly written buffer.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= out_buf[idx];
                  out_last  <= (idx == LAST_SLOT);
               end else if (out_fire) begin
                  if (idx == LAST_SLOT) begin
                     idx       <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= COLLECT;
                  end else begin
                     idx      <= idx_nxt;
                     out_data <= out_buf[idx_nxt];
                     out_last <= (idx_nxt == LAST_SLOT);
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_sort6_framer.sv
// Randomized bench for sort6_framer against a queue-based frame model.
// The model sorts each accepted group of six bytes and predicts handshake and latency behaviour.
module tb_sort6_framer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] acc[$];
   logic [7:0] exp_q[$];
   int         pos = 0;
   int         wait_c = 0;
   logic       held = 1'b0;
   logic [7:0] held_data = 8'd0;
   logic       held_last = 1'b0;
   int         mode = 0;
   int         stall_cnt = 0;

   always #5 clk = ~clk;

   sort6_framer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: observe handshakes at the falling edge, predict the next cycle.
   initial begin
      logic [7:0] srt[$];
      int         j;
      logic       exp_v;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc.delete();
            exp_q.delete();
            pos    = 0;
            wait_c = 0;
            held   = 1'b0;
         end else begin
            exp_v = (exp_q.size() != 0) && (wait_c == 0);
            check("in_ready", in_ready, exp_q.size() == 0);
            check("busy", busy, (acc.size() != 0) || (exp_q.size() != 0));
            check("out_valid", out_valid, exp_v);
            if (out_valid)
               check("out_last", out_last, pos == 5);
            if (held) begin
               check("hold_data", out_data, held_data);
               check("hold_last", out_last, held_last);
            end
            if (wait_c > 0)
               wait_c--;
            if (in_valid && in_ready) begin
               acc.push_back(in_data);
               if (acc.size() == 6) begin
                  srt.delete();
                  foreach (acc[k]) begin
                     j = 0;
                     while (j < srt.size() && srt[j] <= acc[k])
                        j++;
                     srt.insert(j, acc[k]);
                  end
                  foreach (srt[k])
                     exp_q.push_back(srt[k]);
                  acc.delete();
                  wait_c = 2;
               end
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", 1, 0);
               end else begin
                  check("out_data", out_data, exp_q.pop_front());
                  pos = (pos == 5) ? 0 : pos + 1;
               end
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
         end
      end
   end

   // out_ready driver: 0 = always ready, 1 = random, 3 = stall four cycles at element index 2.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            1: out_ready = ($urandom_range(0, 1) == 1);
            3: begin
               if (out_valid && pos == 2 && stall_cnt < 4) begin
                  out_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
         if (mode != 3)
            stall_cnt = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_byte(input logic [7:0] b);
      int k;
      in_valid = 1'b1;
      in_data  = b;
      k = 0;
      while (k < 300) begin
         @(negedge clk);
         if (in_ready)
            break;
         k++;
      end
      check("accept_timeout", k < 300, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_frame(input logic [47:0] f);
      for (int i = 0; i < 6; i++)
         push_byte(f[47 - 8*i -: 8]);
   endtask

   function automatic logic [47:0] rand_frame();
      logic [47:0] r;
      for (int i = 0; i < 6; i++)
         r[8*i +: 8] = 8'($urandom);
      return r;
   endfunction

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || wait_c != 0) && k < 400) begin
         @(posedge clk);
         k++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic garbage(input int n);
      repeat (n) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("init_out_valid", out_valid, 0);
      check("init_out_last", out_last, 0);
      check("init_out_data", out_data, 0);
      check("init_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      push_frame({8'd36, 8'd129, 8'd9, 8'd99, 8'd13, 8'd141});
      drain();
      push_frame({8'd5, 8'd5, 8'd200, 8'd0, 8'd255, 8'd5});
      drain();

      mode = 3;
      push_frame(rand_frame());
      drain();
      check("stall_len", stall_cnt, 4);
      mode = 0;

      for (int i = 0; i < 3; i++)
         push_byte(8'($urandom));
      do_reset();
      push_frame({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
      drain();

      push_frame(rand_frame());
      garbage(6);
      drain();

      push_frame(rand_frame());
      push_frame(rand_frame());
      drain();

      mode = 1;
      for (int i = 0; i < 20; i++)
         push_frame(rand_frame());
      drain();
      mode = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
